cpu_bus_arbiter: RTL

//  Owns the single CPU memory bus. Shares it between instruction fetch (IF), the

---
 rtl/cpu_bus_pkg.sv | 24 ++
 rtl/cpu_bus_arbiter_dma.sv | 132 +++++++++++++
 rtl/cpu_bus_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus arbiter and its OAM DMA engine.
// Ownership and DMA state encodings live here so both files agree on them.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_IE,
        OWN_DMA
    } owner_t;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_ALIGN,
        DMA_READ,
        DMA_WAIT,
        DMA_CAPTURE,
        DMA_WRITE
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/cpu_bus_arbiter_dma.sv
// oam_dma_engine: copies DMA_LEN bytes from page XX00 to OAMDATA ($2004).
// Ports: trig/trig_page latch a request, start marks the grant edge,
// parity aligns the first read, dma_req/dma_busy go to the arbiter,
// dma_addr/dma_data/dma_we drive the bus while DMA owns it.
module oam_dma_engine
    import cpu_bus_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DMA_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [7:0]  trig_page,
    input  logic        start,
    input  logic        parity,
    input  logic [7:0]  mem_data_in,
    output logic        dma_req,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data,
    output logic        dma_we
);

    localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
    localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 2);

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [7:0] wait_q, wait_d;
    logic       busy_q, busy_d;
    logic       last_write;
    logic       accept;

    // A second trigger while a transfer is pending or running is dropped.
    assign accept     = trig && !busy_q;
    assign last_write = (state_q == DMA_WRITE) && (idx_q == LAST_IDX);

    // Request drops during the final write so the arbiter can hand the
    // bus over on the same edge that clears busy.
    assign dma_req  = (busy_q && !last_write) || accept;
    assign dma_busy = busy_q;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wait_d  = wait_q;
        busy_d  = busy_q;

        if (accept) begin
            busy_d = 1'b1;
            page_d = trig_page;
        end

        unique case (state_q)
            DMA_IDLE: begin
                if (start) state_d = DMA_ALIGN;
            end
            // Stays a second cycle when entered on an odd parity cycle.
            DMA_ALIGN: begin
                if (!parity) state_d = DMA_READ;
            end
            DMA_READ: begin
                wait_d  = '0;
                state_d = (READ_LATENCY > 1) ? DMA_WAIT
                                             : DMA_CAPTURE;
            end
            DMA_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = DMA_CAPTURE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DMA_CAPTURE: begin
                data_d  = mem_data_in;
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                if (last_write) begin
                    state_d = DMA_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = DMA_READ;
                end
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    always_comb begin
        dma_addr = '0;
        dma_data = '0;
        dma_we   = 1'b0;
        unique case (state_q)
            DMA_READ, DMA_WAIT, DMA_CAPTURE: begin
                dma_addr = {page_q, idx_q};
            end
            DMA_WRITE: begin
                dma_addr = OAM_DATA_ADDR;
                dma_data = data_q;
                dma_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMA_IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: owns the CPU memory bus and shares it between IF, IE
// and the OAM DMA engine. Ports: if_*/ie_* requester handshakes, mem_*
// bus outputs muxed from the registered owner, mem_data_in, dma_busy.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DMA_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    input  logic        ie_req,
    input  logic [15:0] ie_addr,
    input  logic [7:0]  ie_data_out,
    input  logic        ie_write_en,
    output logic        ie_gnt,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_in,
    output logic        dma_busy
);

    owner_t      owner_q, owner_d;
    logic        parity_q, parity_d;
    logic        bus_free;
    logic        dma_trig;
    logic        dma_req;
    logic        dma_start;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        dma_we;

    assign parity_d = ~parity_q;
    assign if_gnt   = (owner_q == OWN_IF);
    assign ie_gnt   = (owner_q == OWN_IE);
    assign dma_trig = ie_gnt && ie_write_en &&
                      (ie_addr == OAM_DMA_ADDR);

    // Ownership only moves when the bus is idle or the holder lets go;
    // no requester is ever preempted.
    always_comb begin
        bus_free = 1'b1;
        unique case (owner_q)
            OWN_NONE: bus_free = 1'b1;
            OWN_IF:   bus_free = !if_req;
            OWN_IE:   bus_free = !ie_req;
            OWN_DMA:  bus_free = !dma_req;
            default:  bus_free = 1'b1;
        endcase

        owner_d = owner_q;
        if (bus_free) begin
            if (dma_req)     owner_d = OWN_DMA;
            else if (ie_req) owner_d = OWN_IE;
            else if (if_req) owner_d = OWN_IF;
            else             owner_d = OWN_NONE;
        end
    end

    assign dma_start = (owner_d == OWN_DMA) &&
                       (owner_q != OWN_DMA);

    always_comb begin
        mem_addr     = '0;
        mem_data_out = '0;
        mem_write_en = 1'b0;
        unique case (owner_q)
            OWN_IF: begin
                mem_addr = if_addr;
            end
            OWN_IE: begin
                mem_addr     = ie_addr;
                mem_data_out = ie_data_out;
                mem_write_en = ie_write_en;
            end
            OWN_DMA: begin
                mem_addr     = dma_addr;
                mem_data_out = dma_data;
                mem_write_en = dma_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            parity_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            parity_q <= parity_d;
        end
    end

    oam_dma_engine #(
        .READ_LATENCY (READ_LATENCY),
        .DMA_LEN      (DMA_LEN)
    ) u_dma (
        .clk         (clk),
        .rst         (rst),
        .trig        (dma_trig),
        .trig_page   (ie_data_out),
        .start       (dma_start),
        .parity      (parity_q),
        .mem_data_in (mem_data_in),
        .dma_req     (dma_req),
        .dma_busy    (dma_busy),
        .dma_addr    (dma_addr),
        .dma_data    (dma_data),
        .dma_we      (dma_we)
    );

endmodule
